uart_param: RTL and testbench
=============================

UART_PARAM -- requirements
Module: uart_param

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, giving frame data bits (5..8).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 16, giving TX and RX FIFO depth (power of two, at least 2).
REQ-003 The block SHALL have parameter OVERSAMPLE, default 16, giving baud ticks per bit.
REQ-004 The block SHALL have parameter DEFAULT_DIV, default 77, giving the divider reset value (12 MHz, 9600 baud).
REQ-005 The block SHALL have port clk, input, width 1: the single clock.
REQ-006 The block SHALL have port reset, input, width 1: asynchronous, active-high reset.
REQ-007 The block SHALL have port wb_addr, input, width 3: register select.
REQ-008 The block SHALL have port wb_data_in, input, width 8: write data.
REQ-009 The block SHALL have port wb_data_out, output, width 8: read data.
REQ-010 The block SHALL have port wb_we, input, width 1: 1 = write, 0 = read.
REQ-011 The block SHALL have port wb_stb, input, width 1: access request.
REQ-012 The block SHALL have port wb_ack, output, width 1: one-cycle access acknowledge.
REQ-013 The block SHALL have port tx_bit, output, width 1: serial out.
REQ-014 The block SHALL have port rx_bit, input, width 1: serial in, asynchronous.
REQ-015 The block SHALL have port irq, output, width 1: level interrupt.

Function
REQ-016 The register map SHALL be: 0 TX data (W); 1 RX data (R, pops); 2 DIV[7:0]; 3 DIV[15:8]; 4 CTRL; 5 STATUS (R); 6-7 read 0x00, writes ignored.
REQ-017 CTRL SHALL be: [0] tx_en, [1] rx_en, [2] parity_en, [3] parity_odd, [4] two_stop, [5] irq_rx_en (RX not empty), [6] irq_tx_en (TX empty), [7] irq_err_en.
REQ-018 STATUS SHALL be: [0] tx_empty, [1] tx_full, [2] rx_empty, [3] rx_full, [4] overrun, [5] parity_err, [6] frame_err, [7] tx_busy.
REQ-019 On wb_stb high with wb_ack low, the block SHALL assert wb_ack for exactly one cycle on the next edge; wb_data_out SHALL be valid in the ack cycle; wb_ack SHALL be low for at least one cycle between accesses.
REQ-020 A TX write while the TX FIFO is full SHALL be dropped.
REQ-021 An RX read while the RX FIFO is empty SHALL return 0x00 and SHALL not pop.
REQ-022 A STATUS read SHALL clear bits 4-6 after returning them; an error set in the same cycle SHALL win.
REQ-023 The baud counter SHALL run 0..DIV and pulse tick for one cycle at DIV; DIV = 0 SHALL tick every cycle; a DIV write SHALL reset the counter to 0.
REQ-024 The TX FSM SHALL have states IDLE, START, DATA, PARITY, STOP, with each bit lasting OVERSAMPLE ticks and data sent LSB first.
REQ-025 TX IDLE -> START SHALL occur when tx_en = 1 and the FIFO is not empty, popping one entry.
REQ-026 PARITY SHALL be skipped when parity_en = 0.
REQ-027 STOP SHALL last one bit, or two bits when two_stop = 1, then return to IDLE.
REQ-028 CTRL changes SHALL take effect at the next frame start only.
REQ-029 rx_bit SHALL pass a 2-FF synchronizer before any use.
REQ-030 The RX FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-031 RX IDLE -> START SHALL occur on a synced low with rx_en = 1.
REQ-032 In START, a sample at tick OVERSAMPLE/2 that reads high SHALL be a false start and return the FSM to IDLE.
REQ-033 RX data and parity SHALL be sampled mid-bit.
REQ-034 A parity mismatch SHALL set parity_err.
REQ-035 A stop bit sampled low SHALL set frame_err.
REQ-036 A frame with errors SHALL still be pushed.
REQ-037 Only the first stop bit SHALL be checked.
REQ-038 A push while the RX FIFO is full SHALL discard the new byte and set overrun.
REQ-039 Data narrower than 8 bits SHALL be zero-extended on read.
REQ-040 A FIFO push and pop in the same cycle SHALL both take effect, including when full or empty.
REQ-041 irq SHALL equal (irq_rx_en & !rx_empty) | (irq_tx_en & tx_empty) | (irq_err_en & (overrun | parity_err | frame_err)).

Reset
REQ-042 Reset SHALL clear asynchronously: tx_bit = 1, wb_ack = 0, wb_data_out = 0, irq = 0, both FIFOs empty, both FSMs to IDLE, DIV = DEFAULT_DIV, CTRL = 0x03, status errors = 0, synchronizer = 1.
REQ-043 Reset mid-frame SHALL abort the frame and drive tx_bit high immediately.

Structure
REQ-044 The register addresses, CTRL/STATUS bit indices, and FSM state encodings SHALL live in a shared package uart_pkg.
REQ-045 Both FIFOs SHALL be instances of one parametrised sub-module sync_fifo (WIDTH, DEPTH; push, pop, data_out, full, empty, count).

Verification
REQ-046 Write 0x55 with DIV = 0, 8N1 -> tx_bit low 16 cycles, then 1,0,1,0,1,0,1,0 at 16 cycles each, then high; tx_empty = 1 afterwards.
REQ-047 Loop tx_bit to rx_bit, CTRL = 0x07 (even parity), send 0xA3 -> RX read 0xA3, parity bit = 0, STATUS bits 4-6 = 0.
REQ-048 Inject 0x3C with its stop bit forced low -> RX reads 0x3C, frame_err = 1; a second STATUS read returns frame_err = 0.
REQ-049 Send FIFO_DEPTH+1 frames without reading -> rx_full = 1, overrun = 1, the first FIFO_DEPTH bytes are read back intact, and the extra byte is lost.
REQ-050 Drive a 4-tick low glitch on rx_bit -> no push, rx_empty stays 1.
REQ-051 Assert reset mid-DATA -> tx_bit = 1 within the same cycle, DIV reads back 77 (0x4D).

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART: register addresses, CTRL/STATUS bit
// positions and the state encoding used by both the TX and RX engines.
package uart_pkg;

    // Register addresses on the 3-bit bus
    localparam logic [2:0] ADDR_TX     = 3'd0;
    localparam logic [2:0] ADDR_RX     = 3'd1;
    localparam logic [2:0] ADDR_DIV_LO = 3'd2;
    localparam logic [2:0] ADDR_DIV_HI = 3'd3;
    localparam logic [2:0] ADDR_CTRL   = 3'd4;
    localparam logic [2:0] ADDR_STATUS = 3'd5;

    // CTRL bit indices
    localparam int CTRL_TX_EN      = 0;
    localparam int CTRL_RX_EN      = 1;
    localparam int CTRL_PARITY_EN  = 2;
    localparam int CTRL_PARITY_ODD = 3;
    localparam int CTRL_TWO_STOP   = 4;
    localparam int CTRL_IRQ_RX_EN  = 5;
    localparam int CTRL_IRQ_TX_EN  = 6;
    localparam int CTRL_IRQ_ERR_EN = 7;

    // STATUS bit indices
    localparam int STAT_TX_EMPTY   = 0;
    localparam int STAT_TX_FULL    = 1;
    localparam int STAT_RX_EMPTY   = 2;
    localparam int STAT_RX_FULL    = 3;
    localparam int STAT_OVERRUN    = 4;
    localparam int STAT_PARITY_ERR = 5;
    localparam int STAT_FRAME_ERR  = 6;
    localparam int STAT_TX_BUSY    = 7;

    // CTRL value after reset: transmitter and receiver enabled, 8N1, no irqs
    localparam logic [7:0] CTRL_RESET = 8'h03;

    // Frame engine states, shared by TX and RX
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with combinational read port. Pop of an empty FIFO is
// ignored; a push into a full FIFO is accepted only when a pop frees a slot
// in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         data_in,
    output logic [WIDTH-1:0]         data_out,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;
    assign data_out = mem_q[rptr_q];
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);

    // Storage array; no reset needed, occupancy is tracked by the pointers
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= data_in;
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/uart_param.sv
// Parametrised UART with a small register bus, TX/RX FIFOs, programmable
// baud divider with oversampling, optional parity and one or two stop bits.
module uart_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int OVERSAMPLE  = 16,
    parameter int DEFAULT_DIV = 77
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] wb_addr,
    input  logic [7:0] wb_data_in,
    output logic [7:0] wb_data_out,
    input  logic       wb_we,
    input  logic       wb_stb,
    output logic       wb_ack,
    output logic       tx_bit,
    input  logic       rx_bit,
    output logic       irq
);
    localparam int OSW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [OSW-1:0] OS_LAST  = OSW'(OVERSAMPLE - 1);
    localparam logic [OSW-1:0] OS_HALF  = OSW'(OVERSAMPLE / 2 - 1);
    localparam logic [2:0]     BIT_LAST = 3'(DATA_BITS - 1);

    // Bus and configuration registers
    logic                 ack_q;
    logic [7:0]           dout_q;
    logic [15:0]          div_q;
    logic [7:0]           ctrl_q;
    logic [2:0]           err_q;     // [2] frame, [1] parity, [0] overrun
    logic [2:0]           err_d;
    logic [15:0]          baud_q;
    logic [7:0]           rd_data;
    logic [7:0]           status;

    // Bus decode: an access happens on the edge that raises ack
    logic access, wr_en, rd_en, tx_push, rx_pop, status_rd, div_wr, tick;
    assign access    = wb_stb && !ack_q;
    assign wr_en     = access && wb_we;
    assign rd_en     = access && !wb_we;
    assign tx_push   = wr_en && (wb_addr == ADDR_TX);
    assign rx_pop    = rd_en && (wb_addr == ADDR_RX);
    assign status_rd = rd_en && (wb_addr == ADDR_STATUS);
    assign div_wr    = wr_en && ((wb_addr == ADDR_DIV_LO) || (wb_addr == ADDR_DIV_HI));
    assign tick      = (baud_q == div_q);

    // FIFO interfaces
    logic [DATA_BITS-1:0] tx_dout, rx_dout;
    logic                 tx_full, tx_empty, rx_full, rx_empty, tx_pop;
    logic [CW-1:0]        tx_count, rx_count;
    logic                 unused_counts;
    assign unused_counts = ^{tx_count, rx_count};   // occupancy is not in the register map

    // TX engine registers
    uart_state_e          tx_state_q;
    logic [OSW-1:0]       tx_os_q;
    logic [2:0]           tx_idx_q;
    logic [DATA_BITS-1:0] tx_sh_q;
    logic                 tx_par_q, tx_pen_q, tx_two_q, tx_stop2_q, tx_q;

    // RX engine registers
    uart_state_e          rx_state_q;
    logic [OSW-1:0]       rx_os_q;
    logic [2:0]           rx_idx_q;
    logic [DATA_BITS-1:0] rx_sh_q;
    logic                 rx_pen_q, rx_odd_q, rx_perr_q, rx_wait_q;
    logic                 rx_push_q, rx_pset_q, rx_fset_q;
    logic                 sync1_q, sync2_q, rx_s, ovr_set;

    assign rx_s    = sync2_q;
    assign tx_pop  = (tx_state_q == S_IDLE) && ctrl_q[CTRL_TX_EN] && !tx_empty;
    assign ovr_set = rx_push_q && rx_full && !rx_pop;
    // A STATUS read clears the sticky errors, but a new error in that cycle survives
    assign err_d   = (status_rd ? 3'b000 : err_q) | {rx_fset_q, rx_pset_q, ovr_set};
    assign status  = {(tx_state_q != S_IDLE), err_q, rx_full, rx_empty, tx_full, tx_empty};

    assign wb_ack      = ack_q;
    assign wb_data_out = dout_q;
    assign tx_bit      = tx_q;
    assign irq = (ctrl_q[CTRL_IRQ_RX_EN] && !rx_empty) || (ctrl_q[CTRL_IRQ_TX_EN] && tx_empty) ||
                 (ctrl_q[CTRL_IRQ_ERR_EN] && (|err_q));

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .push(tx_push), .pop(tx_pop),
        .data_in(wb_data_in[DATA_BITS-1:0]), .data_out(tx_dout),
        .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .push(rx_push_q), .pop(rx_pop),
        .data_in(rx_sh_q), .data_out(rx_dout),
        .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    // Read data mux; narrow RX data is zero-extended, empty RX reads 0x00
    always_comb begin
        rd_data = 8'h00;
        case (wb_addr)
            ADDR_RX:     if (!rx_empty) rd_data = 8'(rx_dout);
            ADDR_DIV_LO: rd_data = div_q[7:0];
            ADDR_DIV_HI: rd_data = div_q[15:8];
            ADDR_CTRL:   rd_data = ctrl_q;
            ADDR_STATUS: rd_data = status;
            default:     rd_data = 8'h00;
        endcase
    end

    // Bus handshake, register writes, read data capture and sticky errors
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_q  <= 1'b0;
            dout_q <= 8'h00;
            div_q  <= 16'(DEFAULT_DIV);
            ctrl_q <= CTRL_RESET;
            err_q  <= 3'b000;
        end else begin
            ack_q <= access;
            err_q <= err_d;
            if (rd_en) dout_q <= rd_data;
            if (wr_en) begin
                case (wb_addr)
                    ADDR_DIV_LO: div_q[7:0]  <= wb_data_in;
                    ADDR_DIV_HI: div_q[15:8] <= wb_data_in;
                    ADDR_CTRL:   ctrl_q      <= wb_data_in;
                    default:     ;
                endcase
            end
        end
    end

    // Baud tick generator: counts 0..DIV, restarts whenever DIV is written
    always_ff @(posedge clk or posedge reset) begin
        if (reset)           baud_q <= '0;
        else if (div_wr)     baud_q <= '0;
        else if (tick)       baud_q <= '0;
        else                 baud_q <= baud_q + 16'd1;
    end

    // Two-flop synchronizer for the asynchronous serial input
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_bit;
            sync2_q <= sync1_q;
        end
    end

    // TX frame engine; frame format is latched when a byte is popped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q <= S_IDLE;
            tx_os_q    <= '0;
            tx_idx_q   <= '0;
            tx_sh_q    <= '0;
            tx_par_q   <= 1'b0;
            tx_pen_q   <= 1'b0;
            tx_two_q   <= 1'b0;
            tx_stop2_q <= 1'b0;
            tx_q       <= 1'b1;
        end else if (tx_state_q == S_IDLE) begin
            tx_q <= 1'b1;
            if (tx_pop) begin
                tx_state_q <= S_START;
                tx_q       <= 1'b0;
                tx_os_q    <= '0;
                tx_sh_q    <= tx_dout;
                tx_par_q   <= (^tx_dout) ^ ctrl_q[CTRL_PARITY_ODD];
                tx_pen_q   <= ctrl_q[CTRL_PARITY_EN];
                tx_two_q   <= ctrl_q[CTRL_TWO_STOP];
            end
        end else if (tick) begin
            if (tx_os_q != OS_LAST) begin
                tx_os_q <= tx_os_q + OSW'(1);
            end else begin
                tx_os_q <= '0;
                case (tx_state_q)
                    S_START: begin
                        tx_state_q <= S_DATA;
                        tx_idx_q   <= '0;
                        tx_q       <= tx_sh_q[0];
                    end
                    S_DATA: begin
                        if (tx_idx_q == BIT_LAST) begin
                            tx_state_q <= tx_pen_q ? S_PARITY : S_STOP;
                            tx_q       <= tx_pen_q ? tx_par_q : 1'b1;
                            tx_stop2_q <= tx_two_q;
                        end else begin
                            tx_idx_q <= tx_idx_q + 3'd1;
                            tx_sh_q  <= tx_sh_q >> 1;
                            tx_q     <= tx_sh_q[1];
                        end
                    end
                    S_PARITY: begin
                        tx_state_q <= S_STOP;
                        tx_q       <= 1'b1;
                    end
                    S_STOP: begin
                        if (tx_stop2_q) tx_stop2_q <= 1'b0;
                        else            tx_state_q <= S_IDLE;
                    end
                    default: begin
                        tx_state_q <= S_IDLE;
                        tx_q       <= 1'b1;
                    end
                endcase
            end
        end
    end

    // RX frame engine; a low stop bit holds the engine until the line idles
    // high again, so a held-low line is not mistaken for a new start bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_q <= S_IDLE;
            rx_os_q    <= '0;
            rx_idx_q   <= '0;
            rx_sh_q    <= '0;
            rx_pen_q   <= 1'b0;
            rx_odd_q   <= 1'b0;
            rx_perr_q  <= 1'b0;
            rx_wait_q  <= 1'b0;
            rx_push_q  <= 1'b0;
            rx_pset_q  <= 1'b0;
            rx_fset_q  <= 1'b0;
        end else begin
            rx_push_q <= 1'b0;
            rx_pset_q <= 1'b0;
            rx_fset_q <= 1'b0;
            case (rx_state_q)
                S_IDLE: begin
                    if (ctrl_q[CTRL_RX_EN] && !rx_s) begin
                        rx_state_q <= S_START;
                        rx_os_q    <= '0;
                        rx_pen_q   <= ctrl_q[CTRL_PARITY_EN];
                        rx_odd_q   <= ctrl_q[CTRL_PARITY_ODD];
                        rx_perr_q  <= 1'b0;
                        rx_wait_q  <= 1'b0;
                    end
                end
                S_START: if (tick) begin
                    if (rx_os_q == OS_HALF) begin
                        rx_os_q    <= '0;
                        rx_idx_q   <= '0;
                        rx_state_q <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        rx_os_q <= rx_os_q + OSW'(1);
                    end
                end
                S_DATA: if (tick) begin
                    if (rx_os_q == OS_LAST) begin
                        rx_os_q <= '0;
                        rx_sh_q <= {rx_s, rx_sh_q[DATA_BITS-1:1]};
                        if (rx_idx_q == BIT_LAST) rx_state_q <= rx_pen_q ? S_PARITY : S_STOP;
                        else                      rx_idx_q   <= rx_idx_q + 3'd1;
                    end else begin
                        rx_os_q <= rx_os_q + OSW'(1);
                    end
                end
                S_PARITY: if (tick) begin
                    if (rx_os_q == OS_LAST) begin
                        rx_os_q    <= '0;
                        rx_perr_q  <= rx_s != ((^rx_sh_q) ^ rx_odd_q);
                        rx_state_q <= S_STOP;
                    end else begin
                        rx_os_q <= rx_os_q + OSW'(1);
                    end
                end
                S_STOP: begin
                    if (rx_wait_q) begin
                        if (rx_s) begin
                            rx_wait_q  <= 1'b0;
                            rx_state_q <= S_IDLE;
                        end
                    end else if (tick) begin
                        if (rx_os_q == OS_LAST) begin
                            rx_os_q   <= '0;
                            rx_push_q <= 1'b1;
                            rx_pset_q <= rx_perr_q;
                            rx_fset_q <= !rx_s;
                            if (rx_s) rx_state_q <= S_IDLE;
                            else      rx_wait_q  <= 1'b1;
                        end else begin
                            rx_os_q <= rx_os_q + OSW'(1);
                        end
                    end
                end
                default: rx_state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_param.sv
// Directed-plus-random bench for uart_param: serial waveforms and received
// bytes are predicted from frame rules (start, LSB-first data, parity, stops).
`timescale 1ns/1ps
module tb_uart_param;

  localparam int OS = 16;

  typedef bit bitq_t[$];

  // ---------------- clock / reset block ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] wb_addr;
  logic [7:0] wb_data_in;
  logic [7:0] wb_data_out;
  logic       wb_we;
  logic       wb_stb;
  logic       wb_ack;
  logic       tx_bit;
  logic       rx_bit;
  logic       irq;
  logic       loop_en;
  logic       rx_drive;

  always #5 clk = ~clk;

  assign rx_bit = loop_en ? tx_bit : rx_drive;

  uart_param dut (
    .clk(clk), .reset(reset), .wb_addr(wb_addr), .wb_data_in(wb_data_in),
    .wb_data_out(wb_data_out), .wb_we(wb_we), .wb_stb(wb_stb), .wb_ack(wb_ack),
    .tx_bit(tx_bit), .rx_bit(rx_bit), .irq(irq)
  );

  int vectors;
  int miscompares;
  bit cap_en;
  bit trace_q[$];
  logic [7:0] exp_q[$];

  // tx_bit trace, one sample per cycle on the falling edge
  always @(negedge clk) if (cap_en) trace_q.push_back(tx_bit);

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / reference model ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bitq_t frame_bits(input logic [7:0] d, input bit pen, input bit odd, input bit two);
    bitq_t q;
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(d[i]);
    if (pen) q.push_back(bit'($countones(d) % 2) ^ odd);
    q.push_back(1'b1);
    if (two) q.push_back(1'b1);
    return q;
  endfunction

  task automatic check_frame(input string tag, input bitq_t bits);
    int first;
    int idx;
    logic [OS-1:0] obs;
    first = -1;
    for (int i = 0; i < trace_q.size(); i++)
      if (first < 0 && trace_q[i] == 1'b0) first = i;
    check({tag, "_start_found"}, 32'(first >= 0), 1);
    if (first >= 0) begin
      for (int k = 0; k < bits.size(); k++) begin
        for (int j = 0; j < OS; j++) begin
          idx = first + k * OS + j;
          obs[j] = (idx < trace_q.size()) ? trace_q[idx] : 1'bx;
        end
        check($sformatf("%s_bit%0d", tag, k), obs, {OS{bits[k]}});
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wb_write(input logic [2:0] a, input logic [7:0] d);
    wb_addr = a; wb_data_in = d; wb_we = 1'b1; wb_stb = 1'b1;
    @(negedge clk);
    check("wr_ack_high", wb_ack, 1);
    wb_stb = 1'b0; wb_we = 1'b0;
    @(negedge clk);
    check("wr_ack_low", wb_ack, 0);
  endtask

  task automatic wb_read(input logic [2:0] a, output logic [7:0] d);
    wb_addr = a; wb_we = 1'b0; wb_stb = 1'b1;
    @(negedge clk);
    check("rd_ack_high", wb_ack, 1);
    d = wb_data_out;
    wb_stb = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_raw(input logic [7:0] d, input bit pen, input bit odd,
                          input bit bad_par, input bit stop_val);
    bitq_t b;
    b = frame_bits(d, pen, odd, 1'b0);
    if (pen && bad_par) b[9] = !b[9];
    b[b.size() - 1] = stop_val;
    foreach (b[k]) begin
      rx_drive = b[k];
      repeat (OS) @(negedge clk);
    end
    rx_drive = 1'b1;
    repeat (24) @(negedge clk);
  endtask

  task automatic loop_frame(input string tag, input logic [7:0] d, input bit pen,
                            input bit odd, input bit two);
    logic [7:0] r;
    trace_q.delete();
    cap_en = 1'b1;
    wb_write(3'd0, d);
    repeat (230) @(negedge clk);
    cap_en = 1'b0;
    check_frame(tag, frame_bits(d, pen, odd, two));
    exp_q.push_back(d);
    wb_read(3'd1, r);
    check({tag, "_rx"}, r, exp_q.pop_front());
    wb_read(3'd5, r);
    check({tag, "_errs"}, r[6:4], 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] r;
    logic [7:0] d;
    logic [2:0] cfg;
    vectors = 0; miscompares = 0;
    reset = 1'b1; wb_stb = 1'b0; wb_we = 1'b0; wb_addr = 3'd0; wb_data_in = 8'h00;
    loop_en = 1'b0; rx_drive = 1'b1; cap_en = 1'b0;
    repeat (3) @(negedge clk);

    // reset values
    check("rst_tx_bit", tx_bit, 1);
    check("rst_ack", wb_ack, 0);
    check("rst_dout", wb_data_out, 8'h00);
    check("rst_irq", irq, 0);
    reset = 1'b0;
    @(negedge clk);
    wb_read(3'd2, r); check("rst_div_lo", r, 8'h4D);
    wb_read(3'd3, r); check("rst_div_hi", r, 8'h00);
    wb_read(3'd4, r); check("rst_ctrl", r, 8'h03);
    wb_read(3'd5, r); check("rst_status", r, 8'h05);
    wb_write(3'd6, 8'hFF);
    wb_read(3'd6, r); check("addr6_zero", r, 8'h00);
    wb_read(3'd7, r); check("addr7_zero", r, 8'h00);
    wb_read(3'd0, r); check("addr0_read_zero", r, 8'h00);

    // 0x55 at DIV=0, 8N1: start + 1010... LSB first, 16 cycles per bit
    wb_write(3'd2, 8'h00);
    wb_write(3'd3, 8'h00);
    wb_write(3'd4, 8'h01);
    trace_q.delete();
    cap_en = 1'b1;
    wb_write(3'd0, 8'h55);
    repeat (200) @(negedge clk);
    cap_en = 1'b0;
    check_frame("tx55", frame_bits(8'h55, 1'b0, 1'b0, 1'b0));
    wb_read(3'd5, r); check("tx55_status", r, 8'h05);

    // loopback, even parity, 0xA3
    loop_en = 1'b1;
    wb_write(3'd4, 8'h07);
    loop_frame("loopA3", 8'hA3, 1'b1, 1'b0, 1'b0);

    // loopback with random data and random frame formats
    for (int i = 0; i < 6; i++) begin
      cfg = 3'($urandom_range(0, 7));
      d = 8'($urandom);
      wb_write(3'd4, {3'b000, cfg, 2'b11});
      loop_frame($sformatf("rand%0d", i), d, cfg[0], cfg[1], cfg[2]);
    end

    // TX FIFO full: 17th write is dropped
    wb_write(3'd4, 8'h02);
    for (int i = 0; i < 17; i++) begin
      d = 8'($urandom);
      if (i < 16) exp_q.push_back(d);
      wb_write(3'd0, d);
    end
    wb_read(3'd5, r); check("txfull_status", r, 8'h06);
    wb_write(3'd4, 8'h03);
    repeat (2800) @(negedge clk);
    wb_read(3'd5, r); check("txdrain_status", r, 8'h09);
    for (int i = 0; i < 16; i++) begin
      wb_read(3'd1, r);
      check($sformatf("txfull_rx%0d", i), r, exp_q.pop_front());
    end
    wb_read(3'd1, r); check("txfull_extra_lost", r, 8'h00);
    loop_en = 1'b0;

    // framing error: stop bit forced low, byte still delivered
    wb_write(3'd4, 8'h02);
    send_raw(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    wb_read(3'd1, r); check("frm_rx", r, 8'h3C);
    wb_read(3'd5, r); check("frm_status", r, 8'h45);
    wb_read(3'd5, r); check("frm_status_cleared", r, 8'h05);

    // parity error with error interrupt enabled
    wb_write(3'd4, 8'h86);
    send_raw(8'h5A, 1'b1, 1'b0, 1'b1, 1'b1);
    check("perr_irq", irq, 1);
    wb_read(3'd1, r); check("perr_rx", r, 8'h5A);
    wb_read(3'd5, r); check("perr_status", r, 8'h25);
    check("perr_irq_cleared", irq, 0);

    // RX-not-empty interrupt
    wb_write(3'd4, 8'h22);
    send_raw(8'h81, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rxirq_set", irq, 1);
    wb_read(3'd1, r); check("rxirq_rx", r, 8'h81);
    check("rxirq_clear", irq, 0);

    // RX overrun: FIFO_DEPTH+1 frames without reading
    wb_write(3'd4, 8'h02);
    for (int i = 0; i < 17; i++) begin
      d = 8'($urandom);
      if (i < 16) exp_q.push_back(d);
      send_raw(d, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    wb_read(3'd5, r); check("ovr_status", r, 8'h19);
    for (int i = 0; i < 16; i++) begin
      wb_read(3'd1, r);
      check($sformatf("ovr_rx%0d", i), r, exp_q.pop_front());
    end
    wb_read(3'd1, r); check("ovr_empty_read", r, 8'h00);
    wb_read(3'd5, r); check("ovr_status_after", r, 8'h05);

    // 4-cycle low glitch is a false start
    rx_drive = 1'b0;
    repeat (4) @(negedge clk);
    rx_drive = 1'b1;
    repeat (60) @(negedge clk);
    wb_read(3'd5, r); check("glitch_status", r, 8'h05);
    wb_read(3'd1, r); check("glitch_rx", r, 8'h00);

    // reset in the middle of the data bits
    wb_write(3'd2, 8'h03);
    wb_write(3'd4, 8'h01);
    wb_write(3'd0, 8'h00);
    repeat (286) @(negedge clk);
    check("pre_reset_low", tx_bit, 0);
    #2 reset = 1'b1;
    #1;
    check("reset_tx_bit", tx_bit, 1);
    check("reset_ack", wb_ack, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    wb_read(3'd2, r); check("post_rst_div_lo", r, 8'h4D);
    wb_read(3'd3, r); check("post_rst_div_hi", r, 8'h00);
    wb_read(3'd5, r); check("post_rst_status", r, 8'h05);
    check("post_rst_tx_bit", tx_bit, 1);

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
